// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM capture block.
package pwm_pkg;

   localparam int PWM_WIDTH       = 16;
   localparam int PWM_SYNC_STAGES = 2;
   localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_HIGH      = 2'd2,
      ST_LOW       = 2'd3
   } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser for the asynchronous PWM input plus registered rise/fall detection.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic pwm_s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_d;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_d    <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_d    <= w_sync_out;
         r_rise <= w_sync_out & ~r_d;
         r_fall <= ~w_sync_out & r_d;
      end
   end

   // Level is delayed to stay aligned with the registered edge strobes.
   assign pwm_s = r_d;
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform in capture-clock cycles.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH       = PWM_WIDTH,
   parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
   input  logic             chosen_clk,
   input  logic             rst_n,
   input  logic             capture_en,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period_out,
   output logic [WIDTH-1:0] DC_out,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0] C_CNT_MAX = {WIDTH{1'b1}};

   cap_state_e       r_state;
   cap_state_e       w_state_next;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi_len;
   logic [WIDTH-1:0] r_period;
   logic [WIDTH-1:0] r_dc;
   logic             r_valid;
   logic             r_timeout;
   logic             r_stuck;
   logic             w_pwm_s;
   logic             w_rise;
   logic             w_fall;
   logic             w_cnt_max;
   logic             w_emit;
   logic             w_load_hi;
   logic             w_set_to;
   logic             w_cnt_start;
   logic             w_cnt_run;

   pwm_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk    (chosen_clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .pwm_s  (w_pwm_s),
      .rise   (w_rise),
      .fall   (w_fall)
   );

   assign w_cnt_max = (r_cnt == C_CNT_MAX);

   always_ff @(posedge chosen_clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Edges are examined before saturation so an edge always beats a timeout.
   always_comb begin
      w_state_next = r_state;
      w_emit       = 1'b0;
      w_load_hi    = 1'b0;
      w_set_to     = 1'b0;
      w_cnt_start  = 1'b0;
      w_cnt_run    = 1'b0;
      if (!capture_en) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_next = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  w_state_next = ST_HIGH;
                  w_cnt_start  = 1'b1;
               end
            end
            ST_HIGH: begin
               w_cnt_run = 1'b1;
               if (w_fall) begin
                  w_state_next = ST_LOW;
                  w_load_hi    = 1'b1;
               end else if (w_cnt_max) begin
                  w_state_next = ST_WAIT_RISE;
                  w_set_to     = 1'b1;
               end
            end
            ST_LOW: begin
               w_cnt_run = 1'b1;
               if (w_rise) begin
                  w_state_next = ST_HIGH;
                  w_emit       = 1'b1;
                  w_cnt_start  = 1'b1;
               end else if (w_cnt_max) begin
                  w_state_next = ST_WAIT_RISE;
                  w_set_to     = 1'b1;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge chosen_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_hi_len  <= '0;
         r_period  <= '0;
         r_dc      <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_stuck   <= 1'b0;
      end else begin
         r_valid <= w_emit;
         if (!capture_en) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end else begin
            if (w_cnt_start)                 r_cnt <= WIDTH'(1);
            else if (w_cnt_run && !w_cnt_max) r_cnt <= r_cnt + WIDTH'(1);
            if (w_load_hi) r_hi_len <= r_cnt;
            if (w_emit) begin
               r_period  <= r_cnt;
               r_dc      <= r_hi_len;
               r_timeout <= 1'b0;
            end else if (w_set_to) begin
               r_timeout <= 1'b1;
               r_stuck   <= w_pwm_s;
            end
         end
      end
   end

   assign period_out  = r_period;
   assign DC_out      = r_dc;
   assign valid       = r_valid;
   assign timeout     = r_timeout;
   assign stuck_level = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected measurements, a monitor checks each valid.
module tb_pwm_capture;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] per;
      logic [W-1:0] dc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         capture_en = 1'b0;
   logic         pwm_in = 1'b0;
   logic [W-1:0] period_out;
   logic [W-1:0] DC_out;
   logic         valid;
   logic         timeout;
   logic         stuck_level;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   int   vt_q[$];
   exp_t mon_e;

   pwm_capture #(
      .WIDTH       (W),
      .SYNC_STAGES (2)
   ) dut (
      .chosen_clk  (clk),
      .rst_n       (rst_n),
      .capture_en  (capture_en),
      .pwm_in      (pwm_in),
      .period_out  (period_out),
      .DC_out      (DC_out),
      .valid       (valid),
      .timeout     (timeout),
      .stuck_level (stuck_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && valid === 1'b1) begin
         vt_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid=1 at cycle %0d, expected no valid", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            $display("[TB] valid @%0d period_out=%0d DC_out=%0d (exp %0d/%0d)",
                     cyc, period_out, DC_out, mon_e.per, mon_e.dc);
            check("period_out", 32'(period_out), 32'(mon_e.per));
            check("DC_out", 32'(DC_out), 32'(mon_e.dc));
            check("timeout_on_valid", 32'(timeout), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n periods of h high / l low cycles; each period is closed by the next rise.
   task automatic drive(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(exp_t'{per: W'(h + l), dc: W'(h)});
         pwm_in = 1'b1;
         tick(h);
         pwm_in = 1'b0;
         tick(l);
      end
   endtask

   task automatic close_period();
      pwm_in = 1'b1;
      tick(6);
   endtask

   task automatic start_seg();
      capture_en = 1'b0;
      pwm_in     = 1'b0;
      tick(4);
      capture_en = 1'b1;
      tick(4);
   endtask

   task automatic end_seg(input string name);
      tick(2);
      check({name, "_all_seen"}, 32'(exp_q.size()), 32'd0);
      capture_en = 1'b0;
      pwm_in     = 1'b0;
      tick(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      // Reset state
      #2;
      check("rst_period", 32'(period_out), 32'd0);
      check("rst_dc", 32'(DC_out), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_stuck", 32'(stuck_level), 32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // 50% duty, period 6, latency and spacing of valids
      start_seg();
      vt_q.delete();
      c0 = cyc;
      drive(3, 3, 4);
      close_period();
      end_seg("p6");
      check("p6_valid_count", 32'(vt_q.size()), 32'd4);
      if (vt_q.size() == 4) begin
         check("p6_first_latency", 32'(vt_q[0] - c0), 32'd10);
         for (int i = 1; i < 4; i++) check("p6_gap", 32'(vt_q[i] - vt_q[i-1]), 32'd6);
      end

      // Reset mid-run with pwm_in toggling
      start_seg();
      drive(3, 3, 1);
      close_period();
      pwm_in = 1'b0;
      tick(2);
      pwm_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_period", 32'(period_out), 32'd0);
      check("midrst_dc", 32'(DC_out), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_timeout", 32'(timeout), 32'd0);
      for (int i = 0; i < 4; i++) begin
         pwm_in = ~pwm_in;
         tick(1);
      end
      pwm_in = 1'b0;
      rst_n  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(valid), 32'd0);
      end
      tick(1);
      end_seg("rst");

      // 25% then 75% duty at period 4
      start_seg();
      drive(1, 3, 3);
      drive(3, 1, 3);
      close_period();
      end_seg("p4");

      // Stuck high, then recovery with a clean period
      start_seg();
      pwm_in = 1'b1;
      tick(200);
      check("hi_timeout_early", 32'(timeout), 32'd0);
      tick(100);
      check("hi_timeout", 32'(timeout), 32'd1);
      check("hi_stuck", 32'(stuck_level), 32'd1);
      pwm_in = 1'b0;
      tick(4);
      check("hi_timeout_sticky", 32'(timeout), 32'd1);
      drive(2, 2, 1);
      close_period();
      check("hi_timeout_cleared", 32'(timeout), 32'd0);

      // Stuck low after a rise
      pwm_in = 1'b0;
      tick(200);
      check("lo_timeout_early", 32'(timeout), 32'd0);
      tick(100);
      check("lo_timeout", 32'(timeout), 32'd1);
      check("lo_stuck", 32'(stuck_level), 32'd0);
      capture_en = 1'b0;
      tick(2);
      check("lo_timeout_cleared_by_en", 32'(timeout), 32'd0);
      end_seg("stuck");

      // capture_en dropped mid-HIGH and re-raised while pwm_in=1
      start_seg();
      pwm_in = 1'b1;
      tick(5);
      capture_en = 1'b0;
      tick(3);
      capture_en = 1'b1;
      tick(3);
      pwm_in = 1'b0;
      tick(3);
      drive(3, 2, 2);
      close_period();
      end_seg("en");

      // Loopback-style waveform: period 8, high 2
      start_seg();
      drive(2, 6, 3);
      close_period();
      end_seg("loop");

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
